// File: rtl/mem_req_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl_if
//   Memory-side req/ack bus between the MEM-stage request controller and a
//   variable-latency data memory.
//   master : controller side (drives strobe, direction, address, store data)
//   slave  : memory side (drives completion and read data)
// Signals
//   mem_req    1-cycle transaction strobe
//   mem_wr     1=write, 0=read, valid with mem_req
//   mem_addr   byte address
//   mem_wdata  store data
//   mem_ack    completion, mem_rdata valid in the same cycle
//   mem_rdata  read data
// ---------------------------------------------------------------------------
interface mem_req_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl
//   MEM-stage data-memory request controller. A held pipeline MemRead or
//   MemWrite becomes exactly one memory transaction; the pipeline is stalled
//   until the memory acks. Load data and a 1-cycle done pulse are returned.
//   Illegal requests (read and write together) and memory timeouts raise a
//   sticky error that only reset clears.
// Optional feature macro: ALIGN_CHECK_EN
//   defined   : odd address with a request -> error, nothing issued
//   undefined : address bit 0 ignored, mem_addr[0] forced to 0
// Ports
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_req_rd/wr    MemRead/MemWrite, held while o_stall=1
//   i_req_addr     effective address
//   i_req_wdata    store data
//   o_stall        pipeline hold (combinational)
//   o_done         1-cycle completion pulse
//   o_rdata        last completed load data
//   o_err          sticky error
//   mem            memory bus (master modport)
// ---------------------------------------------------------------------------
module mem_req_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_rd,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  mem_req_ctrl_if.master    mem
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_req;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              w_req_any;
  logic              w_req_both;
  logic              w_misalign;
  logic [ADDR_W-1:0] w_addr;

  assign w_req_any  = i_req_rd | i_req_wr;
  assign w_req_both = i_req_rd & i_req_wr;

`ifdef ALIGN_CHECK_EN
  assign w_misalign = i_req_addr[0];
  assign w_addr     = i_req_addr;
`else
  // Word access only: drop the byte-select bit instead of trapping.
  assign w_misalign = 1'b0;
  assign w_addr     = i_req_addr & ~ADDR_W'(1);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      // Strobes are single-cycle; only the transitions below raise them.
      r_mem_req <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_both || (w_req_any && w_misalign)) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else if (w_req_any) begin
            r_mem_wr    <= i_req_wr;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= i_req_wdata;
            r_mem_req   <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // An ack in the last allowed cycle still completes normally.
          if (mem.mem_ack) begin
            if (!r_mem_wr) r_rdata <= mem.mem_rdata;
            r_done  <= 1'b1;
            r_state <= S_RESP;
          end else begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        S_RESP:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_stall = ((r_state == S_IDLE) && w_req_any) ||
                   (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign o_done  = r_done;
  assign o_rdata = r_rdata;
  assign o_err   = r_err;

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_wr    = r_mem_wr;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl, built with TIMEOUT=8.
module tb_mem_req_ctrl;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd, wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          stall, done, err;
  logic [DW-1:0] rdata;

  int n_vec = 0;
  int n_mis = 0;
  int n_memreq = 0;
  int n_done = 0;
  int base_req;

  mem_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mif();

  mem_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_rd   (rd),
    .i_req_wr   (wr),
    .i_req_addr (addr),
    .i_req_wdata(wdata),
    .o_stall    (stall),
    .o_done     (done),
    .o_rdata    (rdata),
    .o_err      (err),
    .mem        (mif)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (mif.mem_req) n_memreq <= n_memreq + 1;
    if (done)        n_done   <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    step(); step();
    chk("rst_stall", stall, 0);
    chk("rst_done",  done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err",   err, 0);
    chk("rst_mreq",  mif.mem_req, 0);
    chk("rst_mwr",   mif.mem_wr, 0);
    chk("rst_maddr", mif.mem_addr, 0);
    chk("rst_mwd",   mif.mem_wdata, 0);
    rst = 1'b0;
    step();

    // Read 0x0010, ack on third WAIT cycle
    rd = 1'b1; addr = 16'h0010; #1;
    chk("rd_c0_stall", stall, 1);
    step();
    chk("rd_iss_mreq", mif.mem_req, 1);
    chk("rd_iss_mwr",  mif.mem_wr, 0);
    chk("rd_iss_addr", mif.mem_addr, 16'h0010);
    chk("rd_iss_stall", stall, 1);
    step();
    chk("rd_w1_mreq", mif.mem_req, 0);
    chk("rd_w1_stall", stall, 1);
    step();
    chk("rd_w2_stall", stall, 1);
    step();
    chk("rd_w3_stall", stall, 1);
    mif.mem_ack = 1'b1; mif.mem_rdata = 16'hBEEF;
    step();
    mif.mem_ack = 1'b0;
    chk("rd_resp_done", done, 1);
    chk("rd_resp_rdata", rdata, 16'hBEEF);
    chk("rd_resp_stall", stall, 0);
    rd = 1'b0;
    step();
    chk("rd_idle_done", done, 0);
    chk("rd_idle_stall", stall, 0);
    chk("rd_nreq", n_memreq, 1);

    // Write 0x0022/0x1234, ack on first WAIT cycle
    wr = 1'b1; addr = 16'h0022; wdata = 16'h1234;
    step();
    chk("wr_iss_mreq", mif.mem_req, 1);
    chk("wr_iss_mwr",  mif.mem_wr, 1);
    chk("wr_iss_addr", mif.mem_addr, 16'h0022);
    chk("wr_iss_wd",   mif.mem_wdata, 16'h1234);
    step();
    mif.mem_ack = 1'b1; mif.mem_rdata = 16'hDEAD;
    step();
    mif.mem_ack = 1'b0; wr = 1'b0;
    chk("wr_c3_done", done, 1);
    chk("wr_rdata_kept", rdata, 16'hBEEF);
    step();

    // Back-to-back read then write
    rd = 1'b1; addr = 16'h0030;
    step();
    step();
    mif.mem_ack = 1'b1; mif.mem_rdata = 16'h5A5A;
    step();
    mif.mem_ack = 1'b0;
    chk("b2b_rd_done", done, 1);
    chk("b2b_rd_data", rdata, 16'h5A5A);
    rd = 1'b0; wr = 1'b1; addr = 16'h0040; wdata = 16'h7777;
    step();
    chk("b2b_idle_done", done, 0);
    chk("b2b_idle_mreq", mif.mem_req, 0);
    chk("b2b_idle_stall", stall, 1);
    step();
    chk("b2b_wr_mreq", mif.mem_req, 1);
    chk("b2b_wr_mwr",  mif.mem_wr, 1);
    chk("b2b_wr_addr", mif.mem_addr, 16'h0040);
    step();
    mif.mem_ack = 1'b1;
    step();
    mif.mem_ack = 1'b0; wr = 1'b0;
    chk("b2b_wr_done", done, 1);
    chk("b2b_rdata", rdata, 16'h5A5A);
    step();
    chk("b2b_nreq", n_memreq, 4);
    chk("b2b_ndone", n_done, 4);

`ifndef ALIGN_CHECK_EN
    // Odd address: bit 0 dropped, normal completion
    rd = 1'b1; addr = 16'h0011;
    step();
    chk("odd_addr", mif.mem_addr, 16'h0010);
    step();
    mif.mem_ack = 1'b1; mif.mem_rdata = 16'h1357;
    step();
    mif.mem_ack = 1'b0; rd = 1'b0;
    chk("odd_done", done, 1);
    chk("odd_rdata", rdata, 16'h1357);
    step();
`endif

    // Ack on the timeout cycle wins
    rd = 1'b1; addr = 16'h0050;
    step();
    for (int w = 1; w <= 8; w++) begin
      step();
      chk("tack_stall", stall, 1);
      if (w == 8) begin
        mif.mem_ack = 1'b1; mif.mem_rdata = 16'h2468;
      end
    end
    step();
    mif.mem_ack = 1'b0; rd = 1'b0;
    chk("tack_done", done, 1);
    chk("tack_err", err, 0);
    chk("tack_rdata", rdata, 16'h2468);
    step();

    // Reset while in WAIT, late ack afterwards
    rd = 1'b1; addr = 16'h0060;
    step();
    step();
    rst = 1'b1; rd = 1'b0;
    step();
    chk("rw_stall", stall, 0);
    chk("rw_rdata", rdata, 0);
    chk("rw_mreq", mif.mem_req, 0);
    chk("rw_maddr", mif.mem_addr, 0);
    chk("rw_err", err, 0);
    rst = 1'b0;
    base_req = n_memreq;
    step();
    step();
    mif.mem_ack = 1'b1; mif.mem_rdata = 16'hFFFF;
    step();
    mif.mem_ack = 1'b0;
    chk("rw_done", done, 0);
    chk("rw_rdata2", rdata, 0);
    chk("rw_stall2", stall, 0);
    step();
    chk("rw_done2", done, 0);
    chk("rw_nreq", n_memreq, base_req);

    // Timeout with no ack
    rd = 1'b1; addr = 16'h0070;
    step();
    for (int w = 1; w <= 8; w++) begin
      step();
      chk("to_wait_err", err, 0);
    end
    step();
    chk("to_err", err, 1);
    chk("to_stall", stall, 0);
    chk("to_mreq", mif.mem_req, 0);
    base_req = n_memreq;
    mif.mem_ack = 1'b1;
    step();
    mif.mem_ack = 1'b0;
    step(); step(); step();
    chk("to_err_sticky", err, 1);
    chk("to_done", done, 0);
    chk("to_nreq", n_memreq, base_req);
    rd = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("to_rst_clr", err, 0);

    // Read and write together
    base_req = n_memreq;
    rd = 1'b1; wr = 1'b1; addr = 16'h0080; #1;
    chk("both_c0_stall", stall, 1);
    step();
    chk("both_err", err, 1);
    chk("both_stall", stall, 0);
    step(); step();
    chk("both_nreq", n_memreq, base_req);
    rd = 1'b0; wr = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    step();

`ifdef ALIGN_CHECK_EN
    // Odd address traps, nothing issued
    base_req = n_memreq;
    rd = 1'b1; addr = 16'h0011;
    step();
    chk("al_err", err, 1);
    chk("al_mreq", mif.mem_req, 0);
    step(); step();
    chk("al_nreq", n_memreq, base_req);
    rd = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
